// File: rtl/quiz_arbiter_n.sv
// quiz_arbiter_n: first-press quiz arbiter with lockout, answer countdown and foul detection
module quiz_arbiter_n #(
   parameter int N_PLAYERS   = 4,
   parameter int ID_W        = 2,
   parameter int CNT_W       = 4,
   parameter int ANSWER_SECS = 9,
   parameter int TICK_DIV    = 100_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_PLAYERS-1:0] btn,
   input  logic                 host_start,
   input  logic                 host_clear,
   output logic [2:0]           state_o,
   output logic                 winner_valid,
   output logic [ID_W-1:0]      winner_id,
   output logic                 foul_valid,
   output logic [ID_W-1:0]      foul_id,
   output logic [CNT_W-1:0]     countdown,
   output logic                 timeout
);
   localparam int DIV_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, ANSWER = 3'd2, TIMEOUT = 3'd3, FOUL = 3'd4} state_t;
   state_t               state, state_n;
   logic [N_PLAYERS-1:0] s1, s2, hist, edg;
   logic [ID_W-1:0]      idx, win_r, foul_r;
   logic [CNT_W-1:0]     cnt;
   logic [DIV_W-1:0]     div;
   logic                 any, wrap;
   assign edg  = s2 & ~hist;
   assign any  = |edg;
   assign wrap = div == DIV_W'(TICK_DIV - 1);
   always_comb begin
      idx = '0;
      for (int i = N_PLAYERS - 1; i >= 0; i--) if (edg[i]) idx = ID_W'(i);
   end
   always_comb begin
      state_n = state;
      if (host_clear) state_n = IDLE;
      else case (state)
         IDLE:    state_n = host_start ? ARMED : any ? FOUL : IDLE;
         ARMED:   state_n = any ? ANSWER : ARMED;
         ANSWER:  state_n = wrap && cnt == CNT_W'(1) ? TIMEOUT : ANSWER;
         default: state_n = state;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= '0;
         s2     <= '0;
         hist   <= '0;
         win_r  <= '0;
         foul_r <= '0;
         cnt    <= '0;
         div    <= '0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         hist <= s2;
         if (host_clear) begin
            win_r  <= '0;
            foul_r <= '0;
            cnt    <= '0;
            div    <= '0;
         end else begin
            if (state == IDLE && !host_start && any) foul_r <= idx;
            if (state == ARMED && any) begin
               win_r <= idx;
               cnt   <= CNT_W'(ANSWER_SECS);
               div   <= '0;
            end
            if (state == ANSWER) begin
               div <= wrap ? '0 : div + DIV_W'(1);
               if (wrap) cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end
   assign state_o      = state;
   assign winner_valid = state == ANSWER || state == TIMEOUT;
   assign winner_id    = win_r;
   assign foul_valid   = state == FOUL;
   assign foul_id      = foul_r;
   assign countdown    = cnt;
   assign timeout      = state == TIMEOUT;
endmodule

// File: tb/tb_quiz_arbiter_n.sv
// tb_quiz_arbiter_n: directed and randomized checks of quiz_arbiter_n against a behavioural model
module tb_quiz_arbiter_n;
   localparam int N = 4, IW = 2, CW = 4, SECS = 3, TD = 10;
   logic          clk = 0, rst = 1, host_start = 0, host_clear = 0;
   logic [N-1:0]  btn = '0;
   logic [2:0]    state_o;
   logic          winner_valid, foul_valid, timeout;
   logic [IW-1:0] winner_id, foul_id;
   logic [CW-1:0] countdown;
   int            tests = 0, failed = 0;
   int            m_state = 0, m_win = 0, m_foul = 0, m_cd = 0, m_cyc = 0;
   logic [N-1:0]  h0 = '0, h1 = '0, h2 = '0;
   quiz_arbiter_n #(.N_PLAYERS(N), .ID_W(IW), .CNT_W(CW), .ANSWER_SECS(SECS), .TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .btn(btn), .host_start(host_start), .host_clear(host_clear),
      .state_o(state_o), .winner_valid(winner_valid), .winner_id(winner_id),
      .foul_valid(foul_valid), .foul_id(foul_id), .countdown(countdown), .timeout(timeout)
   );
   always #5 clk = ~clk;
   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction
   task automatic model_update();
      int e;
      e = lowest(h1 & ~h2);
      if (rst || host_clear) begin
         m_state = 0; m_win = 0; m_foul = 0; m_cd = 0; m_cyc = 0;
      end else if (m_state == 0) begin
         if (host_start) m_state = 1;
         else if (e >= 0) begin m_state = 4; m_foul = e; end
      end else if (m_state == 1) begin
         if (e >= 0) begin m_state = 2; m_win = e; m_cd = SECS; m_cyc = 0; end
      end else if (m_state == 2) begin
         m_cyc++;
         if (m_cyc % TD == 0) m_cd--;
         if (m_cd == 0) m_state = 3;
      end
      if (rst) begin h0 = '0; h1 = '0; h2 = '0; end
      else begin h2 = h1; h1 = h0; h0 = btn; end
   endtask
   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic check_model();
      chk("state_o", int'(state_o), m_state);
      chk("winner_valid", int'(winner_valid), int'(m_state == 2 || m_state == 3));
      chk("winner_id", int'(winner_id), m_win);
      chk("foul_valid", int'(foul_valid), int'(m_state == 4));
      chk("foul_id", int'(foul_id), m_foul);
      chk("countdown", int'(countdown), m_cd);
      chk("timeout", int'(timeout), int'(m_state == 3));
   endtask
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_update();
         #1;
         check_model();
      end
   endtask
   initial begin
      step(2);
      rst = 0;
      chk("reset_state", int'(state_o), 0);
      chk("reset_cd", int'(countdown), 0);
      step(2);
      host_start = 1; step(1); host_start = 0;
      chk("armed", int'(state_o), 1);
      btn = 4'b0100; step(3);
      chk("round_state", int'(state_o), 2);
      chk("round_winner", int'(winner_id), 2);
      chk("round_cd3", int'(countdown), 3);
      step(10); chk("round_cd2", int'(countdown), 2);
      step(10); chk("round_cd1", int'(countdown), 1);
      step(10);
      chk("round_cd0", int'(countdown), 0);
      chk("round_timeout_state", int'(state_o), 3);
      chk("round_timeout", int'(timeout), 1);
      btn = '0; host_clear = 1; step(1); host_clear = 0;
      host_start = 1; step(1); host_start = 0;
      btn = 4'b1010; step(3);
      chk("tie_winner", int'(winner_id), 1);
      btn = 4'b1011; step(3);
      chk("lockout_winner", int'(winner_id), 1);
      chk("lockout_cd", int'(countdown), 3);
      btn = '0; host_clear = 1; step(1); host_clear = 0;
      step(3);
      btn = 4'b1000; step(3);
      chk("foul_state", int'(state_o), 4);
      chk("foul_id", int'(foul_id), 3);
      host_start = 1; step(1); host_start = 0;
      chk("foul_ignores_start", int'(state_o), 4);
      host_clear = 1; step(1); host_clear = 0;
      chk("clear_state", int'(state_o), 0);
      chk("clear_foul_valid", int'(foul_valid), 0);
      chk("clear_foul_id", int'(foul_id), 0);
      btn = '0; step(3);
      btn = 4'b0001; step(2);
      host_start = 1; step(1); host_start = 0;
      step(5);
      chk("held_armed", int'(state_o), 1);
      chk("held_no_foul", int'(foul_valid), 0);
      btn = '0; step(3);
      btn = 4'b0001; step(3);
      chk("repress_state", int'(state_o), 2);
      chk("repress_winner", int'(winner_id), 0);
      step(10);
      chk("mid_cd2", int'(countdown), 2);
      host_clear = 1; step(1); host_clear = 0;
      chk("mid_clear_state", int'(state_o), 0);
      chk("mid_clear_cd", int'(countdown), 0);
      btn = '0; step(3);
      host_start = 1; step(1); host_start = 0;
      btn = 4'b0010; step(3);
      chk("restart_cd3", int'(countdown), 3);
      step(9); chk("restart_hold_cd3", int'(countdown), 3);
      step(1); chk("restart_cd2", int'(countdown), 2);
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) btn[b] = ~btn[b];
         host_start = $urandom_range(15) == 0;
         host_clear = $urandom_range(63) == 0;
         rst = $urandom_range(499) == 0;
         step(1);
      end
      rst = 0; host_start = 0; host_clear = 0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
